// File: rtl/channel_select_ctrl_pkg.sv
// channel_select_ctrl_pkg
//   Shared constants and types for the channel-select input controller.
//   NUM_CH      : number of analog-mux channels
//   CH_W        : width of a channel address
//   sel_state_t : handshake FSM state encoding
//   cnt_width() : width needed for a counter that must hold 0..max_count
package channel_select_ctrl_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    COMMIT   = 2'd2
  } sel_state_t;

  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/channel_select_ctrl_if.sv
// channel_select_ctrl_if
//   Request/acknowledge link between the channel-select controller and the
//   ADC analog-mux controller.
//   chan_req      : request pending (controller -> mux)
//   chan_req_addr : requested channel, stable while chan_req is high
//   chan_ack      : mux has applied the requested address (mux -> controller)
//   master modport: the channel-select controller; slave: the mux controller.
interface channel_select_ctrl_if;
  import channel_select_ctrl_pkg::*;

  logic            chan_req;
  logic [CH_W-1:0] chan_req_addr;
  logic            chan_ack;

  modport master (output chan_req, output chan_req_addr, input chan_ack);
  modport slave  (input chan_req, input chan_req_addr, output chan_ack);

endinterface

// File: rtl/channel_select_ctrl_input_debounce.sv
// channel_select_ctrl_input_debounce
//   Conditions one raw asynchronous front-panel input: two-flop synchroniser
//   followed by a stability counter. The output follows the synchronised
//   value once it has held for DEBOUNCE_CYCLES consecutive cycles.
//   clk    : system clock
//   resetn : synchronous active-low reset (clears all state, output 0)
//   raw    : asynchronous input
//   stable : debounced, synchronous output
module channel_select_ctrl_input_debounce
  import channel_select_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             stable_reg;
  logic [CNT_W-1:0] cnt_reg;

  // For a single bit, "synced value differs from the accepted value" is the
  // run being timed; any bounce back to the accepted value restarts the count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/channel_select_ctrl.sv
// channel_select_ctrl
//   Turns front-panel DIP switches and up/down buttons into a validated
//   channel address for the ADC analog-mux front end. Each new selection is
//   requested over req_if and committed to chan_addr only after chan_ack.
//   clk          : system clock
//   resetn       : synchronous active-low reset
//   sw_raw       : raw DIP switches, one-hot channel select
//   btn_up       : raw pushbutton, next channel
//   btn_dn       : raw pushbutton, previous channel
//   req_if       : chan_req / chan_req_addr out, chan_ack in
//   chan_addr    : committed channel address
//   chan_changed : one-cycle pulse when chan_addr is committed
//   sel_err      : sticky error (ack timeout or several switches set)
module channel_select_ctrl
  import channel_select_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACK_TIMEOUT     = 65535
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_CH-1:0]           sw_raw,
  input  logic                        btn_up,
  input  logic                        btn_dn,
  channel_select_ctrl_if.master       req_if,
  output logic [CH_W-1:0]             chan_addr,
  output logic                        chan_changed,
  output logic                        sel_err
);

  localparam int NUM_IN = NUM_CH + 2;
  localparam int TMR_W  = cnt_width(ACK_TIMEOUT);

  // Input conditioning: switches in the low bits, then up, then down.
  logic [NUM_IN-1:0] raw_bus;
  logic [NUM_IN-1:0] db_bus;

  assign raw_bus = {btn_dn, btn_up, sw_raw};

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_debounce
      channel_select_ctrl_input_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .resetn (resetn),
        .raw    (raw_bus[gi]),
        .stable (db_bus[gi])
      );
    end
  endgenerate

  logic [NUM_CH-1:0] sw_db;
  logic              up_db;
  logic              dn_db;

  assign sw_db = db_bus[NUM_CH-1:0];
  assign up_db = db_bus[NUM_CH];
  assign dn_db = db_bus[NUM_CH+1];

  // State
  logic [NUM_CH-1:0] sw_prev_reg;
  logic              up_prev_reg;
  logic              dn_prev_reg;
  logic [CH_W-1:0]   tgt_reg, tgt_next;
  sel_state_t        state_reg, state_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic              req_reg, req_next;
  logic [CH_W-1:0]   req_addr_reg, req_addr_next;
  logic [CH_W-1:0]   chan_addr_reg, chan_addr_next;
  logic              changed_reg, changed_next;
  logic              sel_err_reg, sel_err_next;

  // Switch decode
  logic [CH_W-1:0] sw_idx;
  int              sw_ones;

  always_comb begin
    sw_idx  = '0;
    sw_ones = $countones(sw_db);
    for (int i = 0; i < NUM_CH; i++) begin
      if (sw_db[i]) begin
        sw_idx = CH_W'(i);
      end
    end
  end

  // Timeout expiry; an ack in the same cycle takes precedence.
  logic abort;
  assign abort = (state_reg == WAIT_ACK) && !req_if.chan_ack &&
                 (timer_reg == TMR_W'(ACK_TIMEOUT - 1));

  // Target select. An abort rolls the target back to the committed address;
  // a switch change or button edge arriving that same cycle applies on top.
  logic [CH_W-1:0] tgt_base;
  logic            sw_changed;
  logic            up_edge;
  logic            dn_edge;
  logic            multi_err;

  always_comb begin
    tgt_base   = abort ? chan_addr_reg : tgt_reg;
    tgt_next   = tgt_base;
    multi_err  = 1'b0;
    sw_changed = (sw_db != sw_prev_reg);
    up_edge    = up_db && !up_prev_reg;
    dn_edge    = dn_db && !dn_prev_reg;
    if (sw_changed) begin
      if (sw_ones == 1) begin
        tgt_next = sw_idx;
      end else if (sw_ones > 1) begin
        multi_err = 1'b1;
      end
    end else if (up_edge && !dn_edge) begin
      tgt_next = (tgt_base == CH_W'(NUM_CH - 1)) ? '0 : tgt_base + CH_W'(1);
    end else if (dn_edge && !up_edge) begin
      tgt_next = (tgt_base == '0) ? CH_W'(NUM_CH - 1) : tgt_base - CH_W'(1);
    end
  end

  // Handshake FSM
  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    req_next       = req_reg;
    req_addr_next  = req_addr_reg;
    chan_addr_next = chan_addr_reg;
    changed_next   = 1'b0;
    sel_err_next   = sel_err_reg | multi_err;
    case (state_reg)
      IDLE: begin
        if (tgt_reg != chan_addr_reg) begin
          req_addr_next = tgt_reg;
          req_next      = 1'b1;
          timer_next    = '0;
          state_next    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (req_if.chan_ack) begin
          req_next   = 1'b0;
          state_next = COMMIT;
        end else if (abort) begin
          req_next     = 1'b0;
          sel_err_next = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      COMMIT: begin
        chan_addr_next = req_addr_reg;
        changed_next   = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sw_prev_reg   <= '0;
      up_prev_reg   <= 1'b0;
      dn_prev_reg   <= 1'b0;
      tgt_reg       <= '0;
      state_reg     <= IDLE;
      timer_reg     <= '0;
      req_reg       <= 1'b0;
      req_addr_reg  <= '0;
      chan_addr_reg <= '0;
      changed_reg   <= 1'b0;
      sel_err_reg   <= 1'b0;
    end else begin
      sw_prev_reg   <= sw_db;
      up_prev_reg   <= up_db;
      dn_prev_reg   <= dn_db;
      tgt_reg       <= tgt_next;
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      req_reg       <= req_next;
      req_addr_reg  <= req_addr_next;
      chan_addr_reg <= chan_addr_next;
      changed_reg   <= changed_next;
      sel_err_reg   <= sel_err_next;
    end
  end

  assign req_if.chan_req      = req_reg;
  assign req_if.chan_req_addr = req_addr_reg;
  assign chan_addr            = chan_addr_reg;
  assign chan_changed         = changed_reg;
  assign sel_err              = sel_err_reg;

endmodule

// File: tb/tb_channel_select_ctrl.sv
// tb_channel_select_ctrl
//   Directed bench for channel_select_ctrl with DEBOUNCE_CYCLES=4 and
//   ACK_TIMEOUT=8. Stimulus pushes the expected request/commit addresses into
//   queues; a monitor pops and compares on each request rise and commit pulse.
module tb_channel_select_ctrl;
  import channel_select_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NUM_CH-1:0] sw_raw = '0;
  logic              btn_up = 1'b0;
  logic              btn_dn = 1'b0;
  logic [CH_W-1:0]   chan_addr;
  logic              chan_changed;
  logic              sel_err;

  channel_select_ctrl_if bus ();

  channel_select_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .ACK_TIMEOUT     (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .sw_raw       (sw_raw),
    .btn_up       (btn_up),
    .btn_dn       (btn_dn),
    .req_if       (bus),
    .chan_addr    (chan_addr),
    .chan_changed (chan_changed),
    .sel_err      (sel_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int req_cnt = 0;
  int commit_cnt = 0;
  int exp_req_q[$];
  int exp_commit_q[$];
  bit ack_en = 1'b0;
  int ack_delay = 1;
  logic prev_req = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.chan_req && !prev_req) begin
        req_cnt++;
        $display("req    addr=%0d  t=%0t", bus.chan_req_addr, $time);
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got request addr %0d, expected no request", bus.chan_req_addr);
        end else begin
          check("req_addr", int'(bus.chan_req_addr), exp_req_q.pop_front());
        end
      end
      if (chan_changed) begin
        commit_cnt++;
        $display("commit addr=%0d  t=%0t", chan_addr, $time);
        if (exp_commit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got commit addr %0d, expected no commit", chan_addr);
        end else begin
          check("commit_addr", int'(chan_addr), exp_commit_q.pop_front());
        end
      end
      prev_req = bus.chan_req;
    end
  end

  // Mux-controller responder: acks ack_delay cycles after seeing a request
  initial begin
    bus.chan_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_en && bus.chan_req) begin
        if (ack_delay > 1) cyc(ack_delay - 1);
        bus.chan_ack = 1'b1;
        cyc(1);
        bus.chan_ack = 1'b0;
      end
    end
  end

  // Wait (bounded) until every expected transaction has been seen
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_req_q.size() != 0 || exp_commit_q.size() != 0) && n < 200) begin
      cyc(1);
      n++;
    end
    check({name, "_drain"}, exp_req_q.size() + exp_commit_q.size(), 0);
    exp_req_q.delete();
    exp_commit_q.delete();
    cyc(10);
  endtask

  task automatic wait_req_rise(input string name);
    int n;
    n = 0;
    while (!bus.chan_req && n < 100) begin
      cyc(1);
      n++;
    end
    check({name, "_req_seen"}, int'(bus.chan_req), 1);
  endtask

  task automatic press(input bit up);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    cyc(6);
    btn_up = 1'b0;
    btn_dn = 1'b0;
  endtask

  initial begin
    int hi;
    int saved;

    // 1: reset and idle
    cyc(3);
    check("rst_req", int'(bus.chan_req), 0);
    check("rst_req_addr", int'(bus.chan_req_addr), 0);
    check("rst_addr", int'(chan_addr), 0);
    check("rst_changed", int'(chan_changed), 0);
    check("rst_err", int'(sel_err), 0);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("idle_req", int'(bus.chan_req), 0);
      check("idle_addr", int'(chan_addr), 0);
      check("idle_changed", int'(chan_changed), 0);
      check("idle_err", int'(sel_err), 0);
    end

    // 2: single switch, ack 3 cycles after request
    ack_en = 1'b1;
    ack_delay = 3;
    exp_req_q.push_back(5);
    exp_commit_q.push_back(5);
    sw_raw = 8'h20;
    wait_done("t2");
    check("t2_addr", int'(chan_addr), 5);
    check("t2_commits", commit_cnt, 1);
    check("t2_err", int'(sel_err), 0);

    // 3: bouncing switch then settle on bit 2
    ack_delay = 1;
    exp_req_q.push_back(2);
    exp_commit_q.push_back(2);
    for (int i = 0; i < 3; i++) begin
      sw_raw = 8'h04;
      cyc(2);
      sw_raw = 8'h00;
      cyc(2);
    end
    check("t3_no_req_bounce", req_cnt, 1);
    sw_raw = 8'h04;
    wait_done("t3");
    check("t3_reqs", req_cnt, 2);
    check("t3_addr", int'(chan_addr), 2);

    // 4: button wrap-around 7 -> 0 -> 7
    exp_req_q.push_back(7);
    exp_commit_q.push_back(7);
    sw_raw = 8'h80;
    wait_done("t4a");
    check("t4a_addr", int'(chan_addr), 7);
    exp_req_q.push_back(0);
    exp_commit_q.push_back(0);
    press(1'b1);
    wait_done("t4b");
    check("t4b_addr", int'(chan_addr), 0);
    exp_req_q.push_back(7);
    exp_commit_q.push_back(7);
    press(1'b0);
    wait_done("t4c");
    check("t4c_addr", int'(chan_addr), 7);
    check("t4_err", int'(sel_err), 0);

    // 5: two switches set -> error, no request; then a valid one
    saved = req_cnt;
    sw_raw = 8'h06;
    cyc(30);
    check("t5_err", int'(sel_err), 1);
    check("t5_no_req", req_cnt, saved);
    check("t5_addr_kept", int'(chan_addr), 7);
    exp_req_q.push_back(3);
    exp_commit_q.push_back(3);
    sw_raw = 8'h08;
    wait_done("t5");
    check("t5_addr", int'(chan_addr), 3);
    check("t5_err_sticky", int'(sel_err), 1);

    // 6: ack timeout (after a reset to clear the sticky error)
    sw_raw = 8'h00;
    resetn = 1'b0;
    cyc(3);
    check("t6_rst_err", int'(sel_err), 0);
    check("t6_rst_addr", int'(chan_addr), 0);
    resetn = 1'b1;
    cyc(10);
    ack_en = 1'b0;
    saved = commit_cnt;
    exp_req_q.push_back(4);
    sw_raw = 8'h10;
    wait_req_rise("t6");
    hi = 0;
    while (bus.chan_req && hi < 100) begin
      hi++;
      cyc(1);
    end
    check("t6_req_cycles", hi, 8);
    cyc(20);
    check("t6_err", int'(sel_err), 1);
    check("t6_addr_kept", int'(chan_addr), 0);
    check("t6_no_commit", commit_cnt, saved);
    check("t6_no_rereq", int'(bus.chan_req), 0);
    ack_en = 1'b1;
    exp_req_q.push_back(1);
    exp_commit_q.push_back(1);
    sw_raw = 8'h02;
    wait_done("t6");
    check("t6_addr", int'(chan_addr), 1);

    // 7: reset during WAIT_ACK
    ack_en = 1'b0;
    exp_req_q.push_back(6);
    sw_raw = 8'h40;
    wait_req_rise("t7");
    cyc(2);
    resetn = 1'b0;
    sw_raw = 8'h00;
    cyc(1);
    check("t7_req_drop", int'(bus.chan_req), 0);
    check("t7_addr_rst", int'(chan_addr), 0);
    cyc(2);
    resetn = 1'b1;
    saved = req_cnt;
    cyc(30);
    check("t7_no_req", req_cnt, saved);
    ack_en = 1'b1;
    exp_req_q.push_back(6);
    exp_commit_q.push_back(6);
    sw_raw = 8'h40;
    wait_done("t7");
    check("t7_addr", int'(chan_addr), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
